audio_system_jtag_tap_host: RTL and testbench

AUDIO_SYSTEM_JTAG_TAP_HOST -- requirements
Module: audio_system_jtag_tap_host

---
 rtl/audio_system_jtag_tap_host.sv | 188 ++++++++++++++++++
 tb/tb_audio_system_jtag_tap_host.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_system_jtag_tap_host.sv
// JTAG TAP host: turns DR/IR scan and TAP-reset commands into TCK/TMS/TDI
// sequences and returns the TDO bits seen while shifting.
module audio_system_jtag_tap_host #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [37:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [37:0] rsp_data,
    output logic        rsp_err,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    typedef enum logic [2:0] {
        RESET_SEQ = 3'd0,
        IDLE      = 3'd1,
        PRE       = 3'd2,
        SHIFT     = 3'd3,
        POST      = 3'd4,
        RESP      = 3'd5
    } state_t;

    localparam logic [1:0] OP_DR    = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_RESET = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;
    localparam logic [5:0] LEN_MAX  = 6'd38;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_reg, state_next;
    logic [5:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  div_cnt_reg;
    logic        tck_reg;
    logic [1:0]  op_reg;
    logic [5:0]  len_reg;
    logic [37:0] data_reg;
    logic [37:0] capt_reg;
    logic        err_reg;

    logic        active;
    logic        phase_end;
    logic        bit_end;
    logic        cmd_fire;
    logic        cmd_bad;
    logic [5:0]  pre_last;
    logic [5:0]  shift_last;

    // A "bit" is one full TCK period; it ends on the clk edge that drops TCK.
    always_comb begin
        active     = (state_reg == RESET_SEQ) || (state_reg == PRE) ||
                     (state_reg == SHIFT) || (state_reg == POST);
        phase_end  = active && (div_cnt_reg == DIV_LAST);
        bit_end    = phase_end && tck_reg;
        cmd_fire   = (state_reg == IDLE) && cmd_valid;
        cmd_bad    = (cmd_op == OP_RSVD) ||
                     ((cmd_op != OP_RESET) && ((cmd_len == 6'd0) || (cmd_len > LEN_MAX)));
        pre_last   = (op_reg == OP_IR) ? 6'd3 : 6'd2;
        shift_last = len_reg - 6'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= RESET_SEQ;
            bit_cnt_reg <= 6'd0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RESET_SEQ: begin
                // op_reg is only OP_RESET here when a command asked for it.
                if (bit_end && (bit_cnt_reg == 6'd5))
                    state_next = (op_reg == OP_RESET) ? RESP : IDLE;
            end
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad)
                        state_next = RESP;
                    else if (cmd_op == OP_RESET)
                        state_next = RESET_SEQ;
                    else
                        state_next = PRE;
                end
            end
            PRE: begin
                if (bit_end && (bit_cnt_reg == pre_last))
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (bit_end && (bit_cnt_reg == shift_last))
                    state_next = POST;
            end
            POST: begin
                if (bit_end && (bit_cnt_reg == 6'd1))
                    state_next = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = RESET_SEQ;
        endcase
    end

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        if (state_next != state_reg)
            bit_cnt_next = 6'd0;
        else if (bit_end)
            bit_cnt_next = bit_cnt_reg + 6'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tck_reg     <= 1'b0;
            div_cnt_reg <= 8'd0;
        end else if (active) begin
            if (phase_end) begin
                tck_reg     <= ~tck_reg;
                div_cnt_reg <= 8'd0;
            end else begin
                div_cnt_reg <= div_cnt_reg + 8'd1;
            end
        end else begin
            tck_reg     <= 1'b0;
            div_cnt_reg <= 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_reg   <= OP_DR;
            len_reg  <= 6'd0;
            data_reg <= 38'd0;
            capt_reg <= 38'd0;
            err_reg  <= 1'b0;
        end else if (cmd_fire) begin
            op_reg   <= cmd_op;
            len_reg  <= cmd_len;
            data_reg <= cmd_data;
            capt_reg <= 38'd0;
            err_reg  <= cmd_bad;
        end else if ((state_reg == SHIFT) && bit_end) begin
            capt_reg[bit_cnt_reg] <= tdo;
        end
    end

    // TMS/TDI derive from state and bit count, which only move when TCK falls.
    always_comb begin
        tms = 1'b0;
        tdi = 1'b0;
        case (state_reg)
            RESET_SEQ: tms = (bit_cnt_reg != 6'd5);
            PRE:       tms = (op_reg == OP_IR) ? (bit_cnt_reg <= 6'd1) : (bit_cnt_reg == 6'd0);
            SHIFT: begin
                tms = (bit_cnt_reg == shift_last);
                tdi = data_reg[bit_cnt_reg];
            end
            POST:      tms = (bit_cnt_reg == 6'd0);
            default: begin
                tms = 1'b0;
                tdi = 1'b0;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_reg == IDLE);
        rsp_valid = (state_reg == RESP);
        rsp_data  = capt_reg;
        rsp_err   = err_reg;
        tck       = tck_reg;
    end

endmodule

// File: tb/tb_audio_system_jtag_tap_host.sv
// Bench for the JTAG TAP host: a tdi->tdo loopback TAP, a per-TCK pin log and
// a sequence model built from the scan rules.
module tb_audio_system_jtag_tap_host;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [37:0] cmd_data = 38'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [37:0] rsp_data;
    logic        rsp_err;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    logic [1:0] tq[$];
    logic       last_tdi = 1'b0;
    logic       prev_tms = 1'b1;
    logic       rsp_seen = 1'b0;

    int          exp_n;
    logic [63:0] exp_tms, exp_tdi, exp_rsp;
    logic        exp_err;

    audio_system_jtag_tap_host #(.CLK_DIV(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Loopback TAP: tdo presents the tdi seen one TCK earlier.
    always @(posedge tck) begin
        tq.push_back({tms, tdi});
        tdo = last_tdi;
        last_tdi = tdi;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("ready_valid_exclusive", 64'(cmd_ready && rsp_valid), 64'd0);
            if (tms !== prev_tms)
                check("tms_change_in_low_phase", 64'(tck), 64'd0);
        end
        prev_tms = tms;
        if (rsp_valid) rsp_seen = 1'b1;
    end

    task automatic push_exp(input logic t, input logic d);
        exp_tms[exp_n] = t;
        exp_tdi[exp_n] = d;
        exp_n++;
    endtask

    task automatic build_exp(input logic [1:0] op, input logic [5:0] len, input logic [37:0] data);
        exp_n = 0; exp_tms = '0; exp_tdi = '0; exp_rsp = '0; exp_err = 1'b0;
        if (op == 2'd3 || (op != 2'd2 && (len == 0 || len > 38))) begin
            exp_err = 1'b1;
        end else if (op == 2'd2) begin
            for (int i = 0; i < 6; i++) push_exp(i < 5, 1'b0);
        end else begin
            push_exp(1'b1, 1'b0);
            if (op == 2'd1) push_exp(1'b1, 1'b0);
            push_exp(1'b0, 1'b0);
            push_exp(1'b0, 1'b0);
            for (int i = 0; i < len; i++) push_exp(i == len - 1, data[i]);
            push_exp(1'b1, 1'b0);
            push_exp(1'b0, 1'b0);
            exp_rsp = ({26'd0, data} << 1) & ((64'd1 << len) - 64'd1);
        end
    endtask

    task automatic pack_obs(output int n, output logic [63:0] t, output logic [63:0] d);
        n = tq.size(); t = '0; d = '0;
        for (int i = 0; i < tq.size() && i < 64; i++) begin
            t[i] = tq[i][1];
            d[i] = tq[i][0];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 64'({tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, rsp_data}),
              64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 38'd0}));
    endtask

    // Called at posedge+1; returns after the handshake edge (+1).
    task automatic send_cmd(input logic [1:0] op, input logic [5:0] len, input logic [37:0] data);
        logic done = 1'b0;
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        for (int c = 0; c < 2000 && !done; c++) begin
            done = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("cmd_handshake", 64'(done), 64'd1);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!cmd_ready && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input logic [5:0] len,
                           input logic [37:0] data, input int hold);
        int n, cyc;
        logic [63:0] ot, od;
        logic [37:0] snap;
        build_exp(op, len, data);
        tq.delete();
        send_cmd(op, len, data);
        cyc = 0;
        while (!rsp_valid && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        if (exp_err) check({name, "_err_latency"}, 64'(cyc), 64'd0);
        pack_obs(n, ot, od);
        check({name, "_tck_count"}, 64'(n), 64'(exp_n));
        check({name, "_tms_seq"}, ot, exp_tms);
        check({name, "_tdi_seq"}, od, exp_tdi);
        check({name, "_rsp_data"}, 64'(rsp_data), exp_rsp);
        check({name, "_rsp_err"}, 64'(rsp_err), 64'(exp_err));
        snap = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold"}, 64'({rsp_valid, cmd_ready, rsp_err, rsp_data}),
                  64'({1'b1, 1'b0, exp_err, snap}));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({name, "_back_to_idle"}, 64'({cmd_ready, rsp_valid}), 64'({1'b1, 1'b0}));
        $display("txn %s op=%0d len=%0d data=%0h tcks=%0d rsp=%0h err=%0b",
                 name, op, len, data, n, rsp_data, rsp_err);
    endtask

    initial begin
        int n, cyc;
        logic [63:0] ot, od;
        logic [1:0]  rop;
        logic [5:0]  rlen;
        logic [37:0] rdata;

        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset_values");

        // Power-up: six TCKs of TMS 1,1,1,1,1,0 then ready after ~24 clks.
        tq.delete();
        reset_n = 1'b1;
        wait_ready(cyc);
        pack_obs(n, ot, od);
        check("powerup_ready_window", 64'(cyc >= 23 && cyc <= 25), 64'd1);
        check("powerup_tck_count", 64'(n), 64'd6);
        check("powerup_tms_seq", ot, 64'h1F);
        check("powerup_tdi_seq", od, 64'h0);
        check("powerup_no_rsp", 64'(rsp_valid), 64'd0);
        $display("txn powerup ready_after=%0d tcks=%0d", cyc, n);

        run_cmd("dr_a5", 2'd0, 6'd8, 38'hA5, 0);
        run_cmd("ir_2aa", 2'd1, 6'd10, 38'h2AA, 0);
        run_cmd("err_len0", 2'd0, 6'd0, 38'h1234, 0);
        run_cmd("err_len39", 2'd1, 6'd39, 38'h1234, 0);
        run_cmd("err_op3", 2'd3, 6'd8, 38'h55, 0);
        run_cmd("tap_reset", 2'd2, 6'd5, 38'h3F, 0);
        run_cmd("dr_38_backpressure", 2'd0, 6'd38, 38'h2B_5A5A_C3C3, 50);
        run_cmd("ir_1bit", 2'd1, 6'd1, 38'h1, 2);

        for (int k = 0; k < 20; k++) begin
            rop   = 2'($urandom_range(0, 3));
            rlen  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(39, 63))
                                                : 6'($urandom_range(1, 38));
            rdata = {6'($urandom), 32'($urandom)};
            run_cmd($sformatf("rand%0d", k), rop, rlen, rdata, $urandom_range(0, 3));
        end

        // Mid-scan reset during shift bit 5 of a 20-bit DR scan.
        tq.delete();
        send_cmd(2'd0, 6'd20, 38'hF_0F0F);
        cyc = 0;
        while (tq.size() < 9 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        check("midscan_reached_bit5", 64'(tq.size()), 64'd9);
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("midscan_async_reset");
        repeat (2) @(posedge clk);
        #1 rsp_seen = 1'b0;
        tq.delete();
        reset_n = 1'b1;
        wait_ready(cyc);
        pack_obs(n, ot, od);
        check("midscan_ready_window", 64'(cyc >= 23 && cyc <= 25), 64'd1);
        check("midscan_reseq_tck_count", 64'(n), 64'd6);
        check("midscan_reseq_tms", ot, 64'h1F);
        check("midscan_no_rsp", 64'(rsp_seen), 64'd0);
        $display("txn midscan_reset ready_after=%0d tcks=%0d", cyc, n);

        run_cmd("after_reset_dr", 2'd0, 6'd12, 38'hABC, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
